vec_lsu: RTL and testbench
==========================

# vec_lsu

Parametrised load/store unit for the vector CPU execute stage. It moves scalar words and full VLEN-bit vector registers between the register files and a single DATA_W-bit memory port, one beat per element. Vector transfers support a programmable byte stride. A start/busy/done handshake lets the control unit stall the pipeline while the unit is busy. It replaces the fixed 64-bit single-beat memory path with one generalised in vector width, word width, memory latency and addressing mode.

## Interface
Parameters:
- VLEN, 64: vector register width in bits; must be an integer multiple of DATA_W.
- DATA_W, 32: memory word width in bits, and the scalar register width.
- ADDR_W, 32: byte-address width.
- MEM_LAT, 1: memory read latency in cycles; legal range 0..7.
- N, derived as VLEN/DATA_W: number of beats (elements) per vector transfer.

Ports:
- clk, in, 1: the single clock; all state is updated on the rising edge.
- reset, in, 1: synchronous, active-low.
- start, in, 1: request to begin an operation; sampled only when busy=0.
- op, in, 2: 00 scalar load, 01 scalar store, 10 vector load, 11 vector store.
- base_addr, in, ADDR_W: byte address of element 0.
- stride, in, ADDR_W: byte increment between vector elements; ignored for scalar ops.
- st_scalar, in, DATA_W: scalar store data.
- st_vec, in, VLEN: vector store data.
- mem_rdata, in, DATA_W: read data from memory.
- mem_addr, out, ADDR_W: memory byte address.
- mem_wdata, out, DATA_W: memory write data.
- mem_we, out, 1: memory write strobe, one cycle per stored word.
- busy, out, 1: an operation is in progress.
- done, out, 1: one-cycle completion pulse.
- ld_scalar, out, DATA_W: result of the last scalar load.
- ld_vec, out, VLEN: result of the last vector load.

## Operation
- The FSM has four states: IDLE, ADDR, WAIT, FIN.
- IDLE + start: latch op, base_addr, stride, st_scalar and st_vec; clear the beat counter k; go to ADDR. The caller may change its inputs after the accept cycle.
- Beat count is N for vector ops and 1 for scalar ops.
- Element k has address base_addr + k*stride, computed modulo 2^ADDR_W (wrap-around is silent).
- Lane order: element k maps to vec[k*DATA_W +: DATA_W], so element 0 is in the LSBs.
- Store, ADDR state: drive mem_addr, mem_wdata = element k and mem_we = 1 for exactly one cycle. Then increment k, or go to FIN after the last beat.
- Load, ADDR state: drive mem_addr. If MEM_LAT = 0, capture mem_rdata at the end of this cycle. Otherwise go to WAIT.
- Load, WAIT state: hold mem_addr for MEM_LAT further cycles. Capture mem_rdata into internal buffer element k at the end of the last WAIT cycle, then advance k or go to FIN.
- FIN state: done = 1 and busy = 0. A load copies the buffer to ld_vec (vector load) or to ld_scalar (scalar load).
- Load results hold until the next load of the same kind completes. Stores never alter ld_scalar or ld_vec.
- start is accepted in FIN exactly as in IDLE, which allows back-to-back operations.
- start while busy=1 is ignored and has no side effects.
- When busy=0: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- reset = 0 (any state, including mid-operation): go to IDLE and clear every output to 0. No done pulse is generated and any partial load is discarded. The memory is not rolled back, so a store beat already issued stays written.

## Timing
- Cycle 0 is the cycle in which start is sampled high. busy = 1 from cycle 1.
- Store: beat k occupies cycle 1+k. done is high in cycle N+1 (vector) or cycle 2 (scalar).
- Load: beat k occupies cycles 1+k(MEM_LAT+1) through (k+1)(MEM_LAT+1). done is high in cycle N(MEM_LAT+1)+1 (vector) or MEM_LAT+2 (scalar).
- ld_scalar and ld_vec show the new value in the done cycle.
- No combinational path from any input to any output; all outputs are registered.
- Reset values: all outputs 0.

## Test plan
Unless noted, parameters are VLEN=64, DATA_W=32, MEM_LAT=1.
- Vector store, base 0x100, stride 4, st_vec = 0x11112222_33334444 -> cycle 1: addr 0x100, wdata 0x33334444, we=1; cycle 2: addr 0x104, wdata 0x11112222, we=1; done in cycle 3, busy 0 in cycle 3.
- Vector load, base 0x200, stride 8, memory returns 0xA at 0x200 and 0xB at 0x208 -> addr 0x200 in cycles 1-2, 0x208 in cycles 3-4; done in cycle 5; ld_vec = 0x0000000B_0000000A; ld_scalar unchanged.
- Vector store, base 0xFFFFFFFC, stride 4 -> beat 1 address is 0x00000000.
- start pulsed in cycle 2 of a vector store -> ignored, still exactly 2 write beats. start in the done cycle -> accepted, next op's first beat in the following cycle.
- reset low during cycle 2 of a vector load with ld_vec previously 0x5 -> next cycle busy=0, ld_vec=0, mem_we=0; done never pulses.
- MEM_LAT=3, scalar load, base 0x40 -> mem_addr=0x40 for cycles 1-4, data captured at the end of cycle 4, done in cycle 5, ld_scalar = word at 0x40, ld_vec unchanged.

Source files
------------

// File: rtl/vec_lsu_if.sv
// Bus bundle between the execute-stage control/memory side and the load/store unit.
interface vec_lsu_if #(
    parameter int unsigned VLEN   = 64,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [DATA_W-1:0] st_scalar;
    logic [VLEN-1:0]   st_vec;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] ld_scalar;
    logic [VLEN-1:0]   ld_vec;

    // Control unit and memory side
    modport master (
        output start, op, base_addr, stride, st_scalar, st_vec, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, ld_scalar, ld_vec
    );

    // Load/store unit side
    modport slave (
        input  start, op, base_addr, stride, st_scalar, st_vec, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, ld_scalar, ld_vec
    );
endinterface

// File: rtl/vec_lsu.sv
// Scalar/vector load-store unit: one DATA_W memory beat per element, strided
// addressing, start/busy/done handshake. All outputs are registered.
module vec_lsu #(
    parameter int unsigned VLEN    = 64,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic       clk,
    input logic       reset,
    vec_lsu_if.slave  bus
);
    localparam int unsigned N     = VLEN / DATA_W;
    localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WLAST = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT, FIN} state_t;

    state_t            state;
    logic [1:0]        op_r;
    logic [ADDR_W-1:0] stride_r;
    logic [VLEN-1:0]   st_vec_r;
    logic [VLEN-1:0]   buf_r;
    logic [KW-1:0]     k;
    logic [2:0]        wcnt;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              mem_we_r;
    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] ld_scalar_r;
    logic [VLEN-1:0]   ld_vec_r;

    logic              accept;
    logic              beat_end;
    logic              last_beat;
    logic [KW-1:0]     k_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [VLEN-1:0]   buf_nxt;

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.ld_scalar = ld_scalar_r;
    assign bus.ld_vec    = ld_vec_r;

    // Beat bookkeeping: end-of-beat detection, next element address/data, buffer merge
    always_comb begin
        accept    = bus.start && (state == IDLE || state == FIN);
        last_beat = !op_r[1] || (k == KW'(N - 1));
        k_inc     = (k == KW'(N - 1)) ? '0 : k + KW'(1);
        addr_nxt  = mem_addr_r + stride_r;
        wdata_nxt = st_vec_r[32'(k_inc) * DATA_W +: DATA_W];
        buf_nxt   = buf_r;
        buf_nxt[32'(k) * DATA_W +: DATA_W] = bus.mem_rdata;
        beat_end  = 1'b0;
        if (state == ADDR) begin
            beat_end = op_r[0] || (MEM_LAT == 0);
        end else if (state == WAIT) begin
            beat_end = (wcnt == 3'(WLAST));
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            op_r        <= '0;
            stride_r    <= '0;
            st_vec_r    <= '0;
            buf_r       <= '0;
            k           <= '0;
            wcnt        <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ld_scalar_r <= '0;
            ld_vec_r    <= '0;
        end else if (accept) begin
            // Latch the request; first beat is driven in the next cycle
            state       <= ADDR;
            op_r        <= bus.op;
            stride_r    <= bus.stride;
            st_vec_r    <= bus.st_vec;
            k           <= '0;
            wcnt        <= '0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            mem_addr_r  <= bus.base_addr;
            mem_we_r    <= bus.op[0];
            mem_wdata_r <= !bus.op[0] ? '0 :
                           (bus.op[1] ? bus.st_vec[DATA_W-1:0] : bus.st_scalar);
        end else begin
            case (state)
                ADDR: begin
                    if (!beat_end) begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end
                end
                WAIT: begin
                    if (!beat_end) begin
                        wcnt <= wcnt + 3'd1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                end
                default: ;
            endcase

            if (beat_end) begin
                if (!op_r[0]) begin
                    buf_r <= buf_nxt;
                end
                if (last_beat) begin
                    state       <= FIN;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    mem_addr_r  <= '0;
                    mem_wdata_r <= '0;
                    mem_we_r    <= 1'b0;
                    if (!op_r[0]) begin
                        if (op_r[1]) begin
                            ld_vec_r <= buf_nxt;
                        end else begin
                            ld_scalar_r <= bus.mem_rdata;
                        end
                    end
                end else begin
                    state       <= ADDR;
                    k           <= k_inc;
                    mem_addr_r  <= addr_nxt;
                    mem_wdata_r <= op_r[0] ? wdata_nxt : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_lsu.sv
// Directed bench for vec_lsu: MEM_LAT=1 instance (a) and MEM_LAT=3 instance (b).
module tb_vec_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [1:0]  op;
    logic [31:0] base, stride, st_s;
    logic [63:0] st_v;
    int          sel;
    int          n_cmp = 0;
    int          n_bad = 0;
    string       cur;

    vec_lsu_if #(.VLEN(64), .DATA_W(32), .ADDR_W(32)) ifa ();
    vec_lsu_if #(.VLEN(64), .DATA_W(32), .ADDR_W(32)) ifb ();

    vec_lsu #(.VLEN(64), .DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    vec_lsu #(.VLEN(64), .DATA_W(32), .ADDR_W(32), .MEM_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    // Memory contents: a few fixed words, otherwise address + 0x1000_0000
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h200: return 32'hA;
            32'h208: return 32'hB;
            32'h500: return 32'h5;
            32'h504: return 32'h0;
            default: return a + 32'h1000_0000;
        endcase
    endfunction

    assign ifa.start = start_a;      assign ifb.start = start_b;
    assign ifa.op = op;              assign ifb.op = op;
    assign ifa.base_addr = base;     assign ifb.base_addr = base;
    assign ifa.stride = stride;      assign ifb.stride = stride;
    assign ifa.st_scalar = st_s;     assign ifb.st_scalar = st_s;
    assign ifa.st_vec = st_v;        assign ifb.st_vec = st_v;
    assign ifa.mem_rdata = mem_fn(ifa.mem_addr);
    assign ifb.mem_rdata = mem_fn(ifb.mem_addr);

    logic [31:0] s_addr, s_wdata, s_lds;
    logic        s_we, s_busy, s_done;
    logic [63:0] s_ldv;
    assign s_addr  = (sel == 1) ? ifb.mem_addr  : ifa.mem_addr;
    assign s_wdata = (sel == 1) ? ifb.mem_wdata : ifa.mem_wdata;
    assign s_we    = (sel == 1) ? ifb.mem_we    : ifa.mem_we;
    assign s_busy  = (sel == 1) ? ifb.busy      : ifa.busy;
    assign s_done  = (sel == 1) ? ifb.done      : ifa.done;
    assign s_lds   = (sel == 1) ? ifb.ld_scalar : ifa.ld_scalar;
    assign s_ldv   = (sel == 1) ? ifb.ld_vec    : ifa.ld_vec;

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [31:0] base;
        logic [31:0] stride;
        logic [31:0] st_s;
        logic [63:0] st_v;
        logic [31:0] a0, a1;   // beat addresses
        logic [31:0] w0, w1;   // beat write data (stores)
        int          done_c;   // cycle in which done is high
        logic [31:0] ld_s;     // ld_scalar in the done cycle
        logic [63:0] ld_v;     // ld_vec in the done cycle
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h (t=%0t)", cur, nm, act, exp, $time);
        end
    endtask

    // Issue one operation and check every cycle up to one past done
    task automatic run_op(input vec_t v);
        int          lat, b;
        logic [31:0] ea, ew;
        logic        st;
        sel = v.sel;
        lat = (v.sel == 1) ? 3 : 1;
        st  = v.op[0];
        op = v.op; base = v.base; stride = v.stride; st_s = v.st_s; st_v = v.st_v;
        start_a = (v.sel == 0);
        start_b = (v.sel == 1);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        op = ~v.op; base = 32'hBAD0_0000; stride = 32'h1; st_s = '1; st_v = '1;
        for (int c = 1; c <= v.done_c + 1; c++) begin
            if (c < v.done_c) begin
                b  = st ? c - 1 : (c - 1) / (lat + 1);
                ea = (b == 0) ? v.a0 : v.a1;
                ew = st ? ((b == 0) ? v.w0 : v.w1) : 32'h0;
                chk($sformatf("busy c%0d", c), 64'(s_busy), 64'h1);
                chk($sformatf("done c%0d", c), 64'(s_done), 64'h0);
                chk($sformatf("addr c%0d", c), 64'(s_addr), 64'(ea));
                chk($sformatf("we c%0d", c), 64'(s_we), 64'(st));
                chk($sformatf("wdata c%0d", c), 64'(s_wdata), 64'(ew));
            end else if (c == v.done_c) begin
                chk("busy@done", 64'(s_busy), 64'h0);
                chk("done@done", 64'(s_done), 64'h1);
                chk("addr@done", 64'(s_addr), 64'h0);
                chk("we@done", 64'(s_we), 64'h0);
                chk("wdata@done", 64'(s_wdata), 64'h0);
                chk("ld_scalar", 64'(s_lds), 64'(v.ld_s));
                chk("ld_vec", s_ldv, v.ld_v);
            end else begin
                chk("done after", 64'(s_done), 64'h0);
                chk("busy after", 64'(s_busy), 64'h0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          sel op     base          stride        st_s          st_v                   a0            a1            w0            w1            done ld_s          ld_v
        tbl[0] = '{0, 2'b00, 32'h300,      32'h0,        32'h0,        64'h0,                 32'h300,      32'h0,        32'h0,        32'h0,        3, 32'h1000_0300, 64'h0};
        tbl[1] = '{0, 2'b11, 32'h100,      32'h4,        32'h0,        64'h11112222_33334444, 32'h100,      32'h104,      32'h33334444, 32'h11112222, 3, 32'h1000_0300, 64'h0};
        tbl[2] = '{0, 2'b10, 32'h200,      32'h8,        32'h0,        64'h0,                 32'h200,      32'h208,      32'h0,        32'h0,        5, 32'h1000_0300, 64'h0000000B_0000000A};
        tbl[3] = '{0, 2'b01, 32'h44,       32'h4,        32'hCAFEF00D, 64'h0,                 32'h44,       32'h0,        32'hCAFEF00D, 32'h0,        2, 32'h1000_0300, 64'h0000000B_0000000A};
        tbl[4] = '{0, 2'b11, 32'hFFFFFFFC, 32'h4,        32'h0,        64'hAAAA5555_12345678, 32'hFFFFFFFC, 32'h0,        32'h12345678, 32'hAAAA5555, 3, 32'h1000_0300, 64'h0000000B_0000000A};
        tbl[5] = '{0, 2'b10, 32'h10,       32'hFFFFFFF0, 32'h0,        64'h0,                 32'h10,       32'h0,        32'h0,        32'h0,        5, 32'h1000_0300, 64'h10000000_10000010};
        tbl[6] = '{0, 2'b10, 32'h500,      32'h4,        32'h0,        64'h0,                 32'h500,      32'h504,      32'h0,        32'h0,        5, 32'h1000_0300, 64'h5};
        tbl[7] = '{1, 2'b10, 32'h200,      32'h8,        32'h0,        64'h0,                 32'h200,      32'h208,      32'h0,        32'h0,        9, 32'h0,         64'h0000000B_0000000A};
        tbl[8] = '{1, 2'b00, 32'h40,       32'h0,        32'h0,        64'h0,                 32'h40,       32'h0,        32'h0,        32'h0,        5, 32'h1000_0040, 64'h0000000B_0000000A};

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 0;
        op = '0; base = '0; stride = '0; st_s = '0; st_v = '0;
        repeat (3) @(negedge clk);

        cur = "reset";
        sel = 0;
        chk("busy", 64'(s_busy), 64'h0);
        chk("done", 64'(s_done), 64'h0);
        chk("addr", 64'(s_addr), 64'h0);
        chk("we", 64'(s_we), 64'h0);
        chk("wdata", 64'(s_wdata), 64'h0);
        chk("ld_scalar", 64'(s_lds), 64'h0);
        chk("ld_vec", s_ldv, 64'h0);
        sel = 1;
        chk("b busy", 64'(s_busy), 64'h0);
        chk("b ld_vec", s_ldv, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            cur = $sformatf("vec%0d", i);
            run_op(tbl[i]);
        end

        // Start while busy is ignored; start in the done cycle is accepted
        cur = "b2b";
        sel = 0;
        op = 2'b11; base = 32'h100; stride = 32'h4; st_v = 64'h11112222_33334444;
        start_a = 1'b1;
        @(negedge clk);                                   // cycle 1
        start_a = 1'b0;
        chk("c1 addr", 64'(s_addr), 64'h100);
        chk("c1 we", 64'(s_we), 64'h1);
        @(negedge clk);                                   // cycle 2
        chk("c2 addr", 64'(s_addr), 64'h104);
        chk("c2 wdata", 64'(s_wdata), 64'h11112222);
        chk("c2 we", 64'(s_we), 64'h1);
        op = 2'b00; base = 32'h900; start_a = 1'b1;       // ignored
        @(negedge clk);                                   // cycle 3
        chk("c3 done", 64'(s_done), 64'h1);
        chk("c3 busy", 64'(s_busy), 64'h0);
        chk("c3 we", 64'(s_we), 64'h0);
        op = 2'b01; base = 32'h80; st_s = 32'h0BAD_CAFE;  // accepted in done cycle
        @(negedge clk);                                   // cycle 4
        start_a = 1'b0; op = 2'b10; base = 32'h0; st_s = 32'h0;
        chk("c4 busy", 64'(s_busy), 64'h1);
        chk("c4 done", 64'(s_done), 64'h0);
        chk("c4 addr", 64'(s_addr), 64'h80);
        chk("c4 we", 64'(s_we), 64'h1);
        chk("c4 wdata", 64'(s_wdata), 64'h0BAD_CAFE);
        @(negedge clk);                                   // cycle 5
        chk("c5 done", 64'(s_done), 64'h1);
        chk("c5 we", 64'(s_we), 64'h0);
        chk("c5 ld_scalar", 64'(s_lds), 64'h1000_0300);
        chk("c5 ld_vec", s_ldv, 64'h5);
        @(negedge clk);                                   // cycle 6
        chk("c6 done", 64'(s_done), 64'h0);
        chk("c6 busy", 64'(s_busy), 64'h0);
        chk("c6 we", 64'(s_we), 64'h0);

        // Reset in the middle of a vector load
        cur = "midreset";
        op = 2'b10; base = 32'h200; stride = 32'h8; start_a = 1'b1;
        @(negedge clk);                                   // cycle 1
        start_a = 1'b0;
        chk("c1 busy", 64'(s_busy), 64'h1);
        chk("c1 addr", 64'(s_addr), 64'h200);
        @(negedge clk);                                   // cycle 2
        reset = 1'b0;
        @(negedge clk);                                   // cycle 3
        chk("busy", 64'(s_busy), 64'h0);
        chk("ld_vec", s_ldv, 64'h0);
        chk("ld_scalar", 64'(s_lds), 64'h0);
        chk("we", 64'(s_we), 64'h0);
        chk("addr", 64'(s_addr), 64'h0);
        chk("done", 64'(s_done), 64'h0);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("after done %0d", c), 64'(s_done), 64'h0);
            chk($sformatf("after busy %0d", c), 64'(s_busy), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
